// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: launches mult/div, waits out latency or div_end, commits Hi/Lo, reports done/errors.
// All outputs registered; md_start is ignored whenever md_busy is high.
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 33,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] div_b_in,
    input  logic        div_end,
    output logic        mult_ctrl,
    output logic        div_ctrl,
    output logic        DIVASelect,
    output logic        DIVBSelect,
    output logic        MDSelect,
    output logic        HiCtrl,
    output logic        LoCtrl,
    output logic        md_busy,
    output logic        md_done,
    output logic        div_zero,
    output logic        md_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MRUN,
        S_DRUN,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_ILL  = 2'b11;
    localparam logic [7:0] MULT_LAST = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LAST  = 8'(DIV_TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [1:0] op_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            op_q       <= 2'b00;
            mult_ctrl  <= 1'b0;
            div_ctrl   <= 1'b0;
            DIVASelect <= 1'b0;
            DIVBSelect <= 1'b0;
            MDSelect   <= 1'b0;
            HiCtrl     <= 1'b0;
            LoCtrl     <= 1'b0;
            md_busy    <= 1'b0;
            md_done    <= 1'b0;
            div_zero   <= 1'b0;
            md_err     <= 1'b0;
        end else begin
            // Single-cycle strobes default low; level outputs are set on state transitions.
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            MDSelect  <= 1'b0;
            HiCtrl    <= 1'b0;
            LoCtrl    <= 1'b0;
            md_done   <= 1'b0;
            div_zero  <= 1'b0;
            md_err    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (md_start) begin
                        op_q    <= md_op;
                        cnt_q   <= 8'd0;
                        md_busy <= 1'b1;
                        if (md_op == OP_MULT) begin
                            state_q   <= S_MRUN;
                            mult_ctrl <= 1'b1;
                        end else if (md_op == OP_ILL) begin
                            state_q <= S_DONE;
                            md_done <= 1'b1;
                            md_err  <= 1'b1;
                        end else if (div_b_in != 32'd0) begin
                            state_q    <= S_DRUN;
                            div_ctrl   <= 1'b1;
                            DIVASelect <= md_op[1];
                            DIVBSelect <= md_op[1];
                        end else begin
                            state_q  <= S_DONE;
                            md_done  <= 1'b1;
                            div_zero <= 1'b1;
                        end
                    end
                end

                S_MRUN: begin
                    if (cnt_q == MULT_LAST) begin
                        state_q  <= S_WB;
                        HiCtrl   <= 1'b1;
                        LoCtrl   <= 1'b1;
                        MDSelect <= (op_q == OP_MULT);
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_DRUN: begin
                    // cnt_q==0 is the div_ctrl cycle: div_end may still reflect the previous divide.
                    if ((cnt_q != 8'd0) && div_end) begin
                        state_q  <= S_WB;
                        HiCtrl   <= 1'b1;
                        LoCtrl   <= 1'b1;
                        MDSelect <= (op_q == OP_MULT);
                    end else if (cnt_q == DIV_LAST) begin
                        state_q    <= S_DONE;
                        md_done    <= 1'b1;
                        md_err     <= 1'b1;
                        DIVASelect <= 1'b0;
                        DIVBSelect <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_WB: begin
                    state_q    <= S_DONE;
                    md_done    <= 1'b1;
                    DIVASelect <= 1'b0;
                    DIVBSelect <= 1'b0;
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    md_busy <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized and directed bench for md_sequencer against a cycle-indexed behavioural model.
module tb_md_sequencer;

    localparam int M = 33;
    localparam int T = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] div_b_in;
    logic        div_end;
    logic        mult_ctrl, div_ctrl, DIVASelect, DIVBSelect, MDSelect;
    logic        HiCtrl, LoCtrl, md_busy, md_done, div_zero, md_err;
    logic [10:0] dut_v;

    int checks = 0;
    int passes = 0;
    bit de [0:127];

    always #5 clk = ~clk;

    md_sequencer #(.MULT_CYCLES(M), .DIV_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
        .div_b_in(div_b_in), .div_end(div_end),
        .mult_ctrl(mult_ctrl), .div_ctrl(div_ctrl),
        .DIVASelect(DIVASelect), .DIVBSelect(DIVBSelect), .MDSelect(MDSelect),
        .HiCtrl(HiCtrl), .LoCtrl(LoCtrl), .md_busy(md_busy), .md_done(md_done),
        .div_zero(div_zero), .md_err(md_err)
    );

    // Bit order: mult_ctrl div_ctrl divA divB mdsel hi lo busy done zero err
    assign dut_v = {mult_ctrl, div_ctrl, DIVASelect, DIVBSelect, MDSelect,
                    HiCtrl, LoCtrl, md_busy, md_done, div_zero, md_err};

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // First cycle (2..T) in which div_end is high; 0 means the divider never answers in time.
    function automatic int first_end();
        for (int t = 2; t <= T; t++) if (de[t]) return t;
        return 0;
    endfunction

    // Expected outputs in cycle t after the accept edge (t=1 is the first cycle after accept).
    function automatic logic [10:0] model(input logic [1:0] op, input logic bz,
                                          input int c_end, input int t);
        logic mc, dc, sel, mds, wr, busy, done, zr, er;
        {mc, dc, sel, mds, wr, busy, done, zr, er} = '0;
        if (op == 2'b00) begin
            busy = (t <= M + 2);
            mc   = (t == 1);
            wr   = (t == M + 1);
            mds  = wr;
            done = (t == M + 2);
        end else if (op == 2'b11) begin
            busy = (t == 1);
            done = (t == 1);
            er   = (t == 1);
        end else if (bz) begin
            busy = (t == 1);
            done = (t == 1);
            zr   = (t == 1);
        end else if (c_end > 0) begin
            busy = (t <= c_end + 2);
            dc   = (t == 1);
            sel  = op[1] && (t <= c_end + 1);
            wr   = (t == c_end + 1);
            done = (t == c_end + 2);
        end else begin
            busy = (t <= T + 1);
            dc   = (t == 1);
            sel  = op[1] && (t <= T);
            done = (t == T + 1);
            er   = done;
        end
        return {mc, dc, sel, sel, mds, wr, wr, busy, done, zr, er};
    endfunction

    // noise: 0 = md_start low while busy, 1 = random, 2 = held high.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] b, input int noise,
                           output int done_at, output int wb_at);
        int c_end, len;
        c_end = first_end();
        if (op == 2'b00)                  len = M + 2;
        else if (op == 2'b11 || b == 0)   len = 1;
        else if (c_end > 0)               len = c_end + 2;
        else                              len = T + 1;
        done_at = -1;
        wb_at   = -1;
        @(negedge clk);
        check("idle_before_request", dut_v, 11'd0);
        md_start = 1'b1;
        md_op    = op;
        div_b_in = b;
        div_end  = 1'($urandom_range(0, 1));
        for (int t = 1; t <= len; t++) begin
            @(negedge clk);
            check($sformatf("op%0d_b%0d_cend%0d_t%0d", op, b, c_end, t), dut_v,
                  model(op, b == 32'd0, c_end, t));
            if (md_done && done_at < 0) done_at = t;
            if (HiCtrl && wb_at < 0) wb_at = t;
            div_end  = de[t];
            md_start = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            md_op    = 2'($urandom_range(0, 3));
            div_b_in = $urandom;
        end
    endtask

    task automatic idle_cycle(input string name);
        @(negedge clk);
        check(name, dut_v, 11'd0);
        md_start = 1'b0;
        div_end  = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_de();
        for (int i = 0; i < 128; i++) de[i] = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at, wb_at;
        logic [1:0] op;
        logic [31:0] b;

        reset    = 1'b0;
        md_start = 1'b1;
        md_op    = 2'b00;
        div_b_in = 32'd5;
        div_end  = 1'b0;
        clear_de();

        // Reset held with md_start asserted must keep everything quiet.
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", dut_v, 11'd0);
        end
        reset    = 1'b1;
        md_start = 1'b0;

        // MULT with md_start pulses during MRUN and DONE.
        for (int i = 0; i < 128; i++) de[i] = 1'($urandom_range(0, 1));
        run_txn(2'b00, 32'd9, 1, done_at, wb_at);
        check_int("mult_wb_cycle", wb_at, 34);
        check_int("mult_done_cycle", done_at, 35);
        idle_cycle("idle_after_mult");

        // DIVM by 7: div_end high during the div_ctrl cycle is ignored, real end on cycle 10.
        clear_de();
        de[1]  = 1'b1;
        de[10] = 1'b1;
        run_txn(2'b10, 32'd7, 0, done_at, wb_at);
        check_int("divm_wb_cycle", wb_at, 11);
        check_int("divm_done_cycle", done_at, 12);

        // Divide by zero, back to back.
        run_txn(2'b01, 32'd0, 0, done_at, wb_at);
        check_int("divzero_done_cycle", done_at, 1);
        check_int("divzero_no_write", wb_at, -1);

        // Timeout: div_end never rises.
        clear_de();
        run_txn(2'b01, 32'd3, 0, done_at, wb_at);
        check_int("timeout_done_cycle", done_at, 65);
        check_int("timeout_no_write", wb_at, -1);

        // div_end coincides with the timeout cycle: completion wins.
        clear_de();
        de[T] = 1'b1;
        run_txn(2'b10, 32'd11, 0, done_at, wb_at);
        check_int("coincide_wb_cycle", wb_at, 65);
        check_int("coincide_done_cycle", done_at, 66);

        // Illegal op.
        run_txn(2'b11, 32'd1, 0, done_at, wb_at);
        check_int("illegal_done_cycle", done_at, 1);

        // md_start held high through a whole op, including DONE, then immediate next request.
        clear_de();
        de[3] = 1'b1;
        run_txn(2'b01, 32'd100, 2, done_at, wb_at);
        check_int("held_start_done_cycle", done_at, 5);
        run_txn(2'b11, 32'd0, 2, done_at, wb_at);

        // Abort mid-DRUN with reset: no WB, no done afterwards.
        clear_de();
        idle_cycle("idle_before_abort");
        @(negedge clk);
        md_start = 1'b1;
        md_op    = 2'b01;
        div_b_in = 32'd9;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            check($sformatf("abort_drun_t%0d", t), dut_v, model(2'b01, 1'b0, 0, t));
            md_start = 1'b0;
            div_end  = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        check("abort_reset_edge", dut_v, 11'd0);
        reset   = 1'b1;
        div_end = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_quiet", dut_v, 11'd0);
        end

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            clear_de();
            de[1] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: ;
                1: de[$urandom_range(2, T)] = 1'b1;
                default: de[$urandom_range(2, 12)] = 1'b1;
            endcase
            for (int i = T + 1; i < 128; i++) de[i] = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_txn(op, b, 1, done_at, wb_at);
            check_int($sformatf("rand%0d_one_done", n), (done_at > 0) ? 1 : 0, 1);
            repeat ($urandom_range(0, 2)) idle_cycle("rand_gap");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
